ppu_fir_encoder_seq: RTL and testbench
======================================

Name: ppu_fir_encoder_seq

Overview:
- Iterative FIR-to-posit encoder on the output side of the PPU ops stage.
- Consumes an unrounded long FIR plus its truncation sticky bit, builds the regime serially, applies round-to-nearest-even and clamping, and emits an N-bit posit.
- It is the counterpart of the posit-to-FIR decoder at the PPU input.
- Uses a valid/ready handshake on both sides and accepts one transaction at a time.

Parameters:
- N, 16: posit width.
- ES, 1: posit exponent width.
- Derived, not overridable:
  - S = clog2(N).
  - TE_BITS = (ES+1)+(S+1).
  - MS = N-2.
  - FRAC_FULL_SIZE = 3*MS-2 (40 at N=16).
  - W_BITS = 1+ES+FRAC_FULL_SIZE.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  input transaction valid.
- ready_o  out  1  encoder idle and able to accept.
- sign_i  in  1  FIR sign.
- te_i  in  TE_BITS  signed total exponent.
- frac_i  in  FRAC_FULL_SIZE  fraction without hidden bit; MSB weight 2^-1.
- frac_truncated_i  in  1  sticky from ops stage.
- special_i  in  1  special tag (zero/NaR); bypasses encoding.
- special_posit_i  in  N  posit forwarded when special_i=1.
- valid_o  out  1  posit_o valid.
- ready_i  in  1  downstream accepts.
- posit_o  out  N  encoded posit.

Behaviour:
- Interface:
  - One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset:
  - state=IDLE, valid_o=0, posit_o=0, counter=0, sticky=0.
  - ready_o=1 in the first cycle after reset.
  - Reset asserted in any state aborts the transaction; no output is produced.
- ready_o:
  - Equals (state==IDLE), combinational.
  - Inputs are sampled only on the accept edge (valid_i & ready_o).
- Decomposition:
  - k = te_i >>> ES (arithmetic shift).
  - e = te_i[ES-1:0].
- IDLE, on accept, the first matching rule applies:
  - special_i=1: posit_r=special_posit_i; go to OUT.
  - k >= N-2: posit_r = sign_i ? 1000..01 : 0111..11 (±maxpos); go to OUT.
  - k <= -(N-1): posit_r = sign_i ? 1111..11 : 0000..01 (±minpos); go to OUT.
  - Otherwise:
    - R = (k>=0) ? k+1 : -k, with range 1..N-2.
    - Load W = {term, e, frac_i}, term = (k>=0) ? 0 : 1.
    - fill = (k>=0) ? 1 : 0; counter = R; sticky = frac_truncated_i; go to SHIFT.
- SHIFT:
  - Each edge: W = {fill, W[W_BITS-1:1]}; sticky |= W[0]; counter--.
  - Go to ROUND on the edge where counter reaches 0.
- ROUND:
  - body = W[W_BITS-1 -: N-1].
  - g = W[W_BITS-N].
  - st = sticky | OR(W[W_BITS-N-1:0]).
  - rnd = g & (st | body[0]).
  - sum = body + rnd, (N-1)-bit. If it carries out (body all ones), sum = all ones (maxpos clamp).
  - sum is never 0 because the regime always contains a 1.
  - posit_r = sign ? (~{0,sum}+1) : {0,sum}; go to OUT.
- OUT:
  - valid_o=1 and posit_o=posit_r.
  - Both are held stable while ready_i=0.
  - On valid_o & ready_i go to IDLE, with valid_o=0 on the next cycle.
  - No accept can occur in the same cycle (ready_o=0), so there is no back-to-back overlap.
- Latency, counted from the accept edge to the first cycle with valid_o=1:
  - Bypass (special or clamp): 1 edge.
  - Normal: R+2 edges.
  - Throughput: one transaction per (latency + 1 + downstream stall) cycles.
- Width rules:
  - All te/k arithmetic is signed, TE_BITS wide.
  - counter is S+1 bits.
  - W_BITS >= N+1 is guaranteed for N >= 4.
- X handling: inputs other than valid_i are don't-care when valid_i=0.

Test Plan:
All cases use N=16, ES=1, frac_truncated_i=0 and ready_i=1 unless stated.
1. te=0, frac=0:
   - sign=0 -> posit_o=0x4000, valid_o 3 edges after accept.
   - sign=1 -> 0xC000.
2. te=-1, frac=0 -> 0x3000 (0.5).
3. Rounding with te=0 and frac_i = only bit[27] set (the guard bit):
   - 0x4000 (tie, even, no round-up).
   - Same with frac_truncated_i=1 -> 0x4001.
   - Same with frac_i bits[28:27] set -> 0x4002 (tie, odd LSB, round-up).
4. Clamp and regime edge:
   - te=40 -> 0x7FFF after 1 edge; with sign=1 -> 0x8001.
   - te=-40 -> 0x0001.
   - te=26, frac=0 -> 0x7FFE, valid_o 16 edges after accept.
5. Special: special_i=1, special_posit_i=0x8000 -> 0x8000 after 1 edge, ignoring te/frac.
6. Backpressure and reset:
   - Hold ready_i=0 for 5 cycles in OUT -> posit_o and valid_o stable, ready_o=0, new valid_i ignored.
   - Assert rst_i during SHIFT -> valid_o never rises, ready_o=1 the next cycle.

Source files
------------

// File: rtl/ppu_fir_encoder_seq.sv
// Iterative FIR-to-posit encoder: serial regime build, round-to-nearest-even, clamp.
module ppu_fir_encoder_seq #(
    parameter  int unsigned N              = 16,
    parameter  int unsigned ES             = 1,
    localparam int unsigned S              = $clog2(N),
    localparam int unsigned TE_BITS        = (ES + 1) + (S + 1),
    localparam int unsigned MS             = N - 2,
    localparam int unsigned FRAC_FULL_SIZE = 3 * MS - 2,
    localparam int unsigned W_BITS         = 1 + ES + FRAC_FULL_SIZE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      sign_i,
    input  logic [TE_BITS-1:0]        te_i,
    input  logic [FRAC_FULL_SIZE-1:0] frac_i,
    input  logic                      frac_truncated_i,
    input  logic                      special_i,
    input  logic [N-1:0]              special_posit_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [N-1:0]              posit_o
);

    localparam int unsigned CW = S + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic signed [TE_BITS-1:0] K_MAX = TE_BITS'(N - 2);
    localparam logic signed [TE_BITS-1:0] K_MIN = TE_BITS'(-(N - 1));

    localparam logic [N-1:0] MAXPOS     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MAXPOS = {1'b1, {(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0] MINPOS     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NEG_MINPOS = {N{1'b1}};

    logic [1:0]        state_q, state_n;
    logic [W_BITS-1:0] w_q, w_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              sticky_q, sticky_n;
    logic              fill_q, fill_n;
    logic              sign_q, sign_n;
    logic [N-1:0]      posit_q, posit_n;
    logic              valid_q, valid_n;

    logic signed [TE_BITS-1:0] k;
    logic                      k_neg;
    logic signed [TE_BITS-1:0] r_len;
    logic [ES-1:0]             e;

    logic [N-2:0] body;
    logic         guard;
    logic         st;
    logic         rnd;
    logic [N-1:0] sum_ext;
    logic [N-2:0] sum;
    logic [N-1:0] mag;
    logic [N-1:0] rounded;

    // Split the total exponent into regime k and exponent e; derive regime run length.
    always_comb begin
        k     = $signed(te_i) >>> ES;
        k_neg = k[TE_BITS-1];
        r_len = k_neg ? -k : k + TE_BITS'(1);
        e     = te_i[ES-1:0];
    end

    // Round-to-nearest-even on the shifted word, clamp carry-out to maxpos, apply sign.
    always_comb begin
        body    = w_q[W_BITS-1 -: N-1];
        guard   = w_q[W_BITS-N];
        st      = sticky_q | (|w_q[W_BITS-N-1:0]);
        rnd     = guard & (st | body[0]);
        sum_ext = {1'b0, body} + N'(rnd);
        sum     = sum_ext[N-1] ? {(N-1){1'b1}} : sum_ext[N-2:0];
        mag     = {1'b0, sum};
        rounded = sign_q ? (~mag + N'(1)) : mag;
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign posit_o = posit_q;

    // Next-state and datapath update.
    always_comb begin
        state_n  = state_q;
        w_n      = w_q;
        cnt_n    = cnt_q;
        sticky_n = sticky_q;
        fill_n   = fill_q;
        sign_n   = sign_q;
        posit_n  = posit_q;
        valid_n  = valid_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sign_n = sign_i;
                    if (special_i) begin
                        posit_n = special_posit_i;
                        valid_n = 1'b1;
                        state_n = OUT;
                    end else if (k >= K_MAX) begin
                        posit_n = sign_i ? NEG_MAXPOS : MAXPOS;
                        valid_n = 1'b1;
                        state_n = OUT;
                    end else if (k <= K_MIN) begin
                        posit_n = sign_i ? NEG_MINPOS : MINPOS;
                        valid_n = 1'b1;
                        state_n = OUT;
                    end else begin
                        w_n      = {k_neg, e, frac_i};
                        fill_n   = ~k_neg;
                        cnt_n    = CW'(r_len);
                        sticky_n = frac_truncated_i;
                        state_n  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_n      = {fill_q, w_q[W_BITS-1:1]};
                sticky_n = sticky_q | w_q[0];
                cnt_n    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                posit_n = rounded;
                valid_n = 1'b1;
                state_n = OUT;
            end
            OUT: begin
                if (ready_i) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            w_q      <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            fill_q   <= 1'b0;
            sign_q   <= 1'b0;
            posit_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            w_q      <= w_n;
            cnt_q    <= cnt_n;
            sticky_q <= sticky_n;
            fill_q   <= fill_n;
            sign_q   <= sign_n;
            posit_q  <= posit_n;
            valid_q  <= valid_n;
        end
    end

endmodule

// File: tb/tb_ppu_fir_encoder_seq.sv
// Directed bench for ppu_fir_encoder_seq with a value-level posit rounding model.
module tb_ppu_fir_encoder_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        sign_i;
    logic [6:0]  te_i;
    logic [39:0] frac_i;
    logic        frac_truncated_i;
    logic        special_i;
    logic [15:0] special_posit_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] posit_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_posit = 16'h0;

    ppu_fir_encoder_seq #(.N(16), .ES(1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .sign_i           (sign_i),
        .te_i             (te_i),
        .frac_i           (frac_i),
        .frac_truncated_i (frac_truncated_i),
        .special_i        (special_i),
        .special_posit_i  (special_posit_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .posit_o          (posit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Value-level model: concatenate regime|e|frac as one integer and round the top 15 bits.
    function automatic logic [15:0] model(input bit s, input int te, input logic [39:0] f,
                                          input bit tr, input bit sp, input logic [15:0] spp);
        int k, rl, len;
        logic [63:0] regime, full, rem, one;
        logic [15:0] body, mag;
        bit g, stk, rnd;
        one = 64'd1;
        if (sp) return spp;
        k = te >>> 1;
        if (k >= 14) return s ? 16'h8001 : 16'h7FFF;
        if (k <= -15) return s ? 16'hFFFF : 16'h0001;
        if (k >= 0) begin
            rl = k + 2;
            regime = ((one << (k + 1)) - one) << 1;
        end else begin
            rl = 1 - k;
            regime = one;
        end
        full = (regime << 41) | (64'(te & 1) << 40) | 64'(f);
        len  = rl + 41;
        body = 16'(full >> (len - 15));
        rem  = full & ((one << (len - 15)) - one);
        g    = rem[len - 16];
        stk  = tr || ((rem & ((one << (len - 16)) - one)) != 64'd0);
        rnd  = g && (stk || body[0]);
        mag  = body + 16'(rnd);
        if (mag[15]) mag = 16'h7FFF;
        return s ? (16'h0 - mag) : mag;
    endfunction

    function automatic int model_lat(input int te, input bit sp);
        int k;
        k = te >>> 1;
        if (sp || k >= 14 || k <= -15) return 1;
        return (k >= 0) ? k + 3 : 2 - k;
    endfunction

    // Whenever a posit is presented it must match the outstanding transaction.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            check("mon_posit", 32'(posit_o), 32'(exp_posit));
            check("mon_ready_low", 32'(ready_o), 32'd0);
        end
    end

    task automatic scramble();
        sign_i           = 1'($urandom);
        te_i             = 7'($urandom);
        frac_i           = {8'($urandom), 32'($urandom)};
        frac_truncated_i = 1'($urandom);
        special_i        = 1'($urandom);
        special_posit_i  = 16'($urandom);
    endtask

    task automatic run(input string name, input bit s, input int te, input logic [39:0] f,
                       input bit tr, input bit sp, input logic [15:0] spp,
                       input bit has_lit, input logic [15:0] lit, input int hold);
        int lat;
        int elat;
        logic [15:0] m;
        m    = model(s, te, f, tr, sp, spp);
        elat = model_lat(te, sp);
        if (has_lit) check({name, "_model"}, 32'(m), 32'(lit));
        exp_posit        = m;
        sign_i           = s;
        te_i             = 7'(te);
        frac_i           = f;
        frac_truncated_i = tr;
        special_i        = sp;
        special_posit_i  = spp;
        ready_i          = (hold == 0);
        valid_i          = 1'b1;
        check({name, "_ready_idle"}, 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        scramble();
        lat = 1;
        while (!valid_o && lat < 64) begin
            step();
            lat++;
        end
        check({name, "_valid"}, 32'(valid_o), 32'd1);
        check({name, "_posit"}, 32'(posit_o), 32'(m));
        if (has_lit) check({name, "_lit"}, 32'(posit_o), 32'(lit));
        check({name, "_latency"}, 32'(lat), 32'(elat));
        for (int i = 0; i < hold; i++) begin
            valid_i = 1'b1;
            step();
            check({name, "_hold_valid"}, 32'(valid_o), 32'd1);
            check({name, "_hold_posit"}, 32'(posit_o), 32'(m));
            check({name, "_hold_ready"}, 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check({name, "_drain_valid"}, 32'(valid_o), 32'd0);
        check({name, "_drain_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        scramble();
        step();
        step();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_posit", 32'(posit_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        rst_i = 1'b0;
        step();
        check("post_rst_ready", 32'(ready_o), 32'd1);

        run("one",       0,   0, 40'h0,          0, 0, 16'h0,    1, 16'h4000, 0);
        run("neg_one",   1,   0, 40'h0,          0, 0, 16'h0,    1, 16'hC000, 0);
        run("half",      0,  -1, 40'h0,          0, 0, 16'h0,    1, 16'h3000, 0);
        run("tie_even",  0,   0, 40'h00_0800_0000, 0, 0, 16'h0,  1, 16'h4000, 0);
        run("tie_stk",   0,   0, 40'h00_0800_0000, 1, 0, 16'h0,  1, 16'h4001, 0);
        run("tie_odd",   0,   0, 40'h00_1800_0000, 0, 0, 16'h0,  1, 16'h4002, 0);
        run("clamp_max", 0,  40, 40'h0,          0, 0, 16'h0,    1, 16'h7FFF, 0);
        run("clamp_nmax",1,  40, 40'h0,          0, 0, 16'h0,    1, 16'h8001, 0);
        run("clamp_min", 0, -40, 40'h0,          0, 0, 16'h0,    1, 16'h0001, 0);
        run("edge_hi",   0,  26, 40'h0,          0, 0, 16'h0,    1, 16'h7FFE, 0);
        run("edge_rnd",  0,  27, 40'h12_3456_789A, 0, 0, 16'h0,  1, 16'h7FFF, 0);
        run("edge_lo",   0, -28, 40'h0,          0, 0, 16'h0,    1, 16'h0001, 0);
        run("edge_lo_r", 0, -27, 40'h0,          0, 0, 16'h0,    1, 16'h0002, 0);
        run("special",   0,   5, 40'hFF_FFFF_FFFF, 1, 1, 16'h8000, 1, 16'h8000, 0);
        run("mid_neg",   1,   7, 40'hA5_5A5A_F00F, 0, 0, 16'h0,  0, 16'h0, 0);
        run("frac_neg",  0, -9, 40'h80_0000_0001, 0, 0, 16'h0,   0, 16'h0, 0);
        run("backpress", 0,   3, 40'h40_0000_0000, 0, 0, 16'h0,  0, 16'h0, 5);

        // Abort a long transaction mid-shift.
        exp_posit = model(0, 26, 40'h0, 0, 0, 16'h0);
        sign_i = 1'b0;
        te_i = 7'd26;
        frac_i = 40'h0;
        frac_truncated_i = 1'b0;
        special_i = 1'b0;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        step();
        step();
        check("abort_ready_busy", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort_quiet", 32'(valid_o), 32'd0);
        end
        run("after_abort", 1, -1, 40'h0, 0, 0, 16'h0, 1, 16'hD000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
